// File: rtl/access_pattern_gen_if.sv
// Handshake/bus bundle between the access-pattern generator and the cache.
// master: the generator (drives addr and status); slave: the consumer side
// (drives start, mode, stall).
interface access_pattern_gen_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  start;
    logic [1:0]            mode;
    logic                  stall;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  addr_valid;
    logic                  busy;
    logic                  done;
    logic [31:0]           access_count;
    logic [1:0]            phase;

    modport master (
        input  start,
        input  mode,
        input  stall,
        output addr,
        output addr_valid,
        output busy,
        output done,
        output access_count,
        output phase
    );

    modport slave (
        output start,
        output mode,
        output stall,
        input  addr,
        input  addr_valid,
        input  busy,
        input  done,
        input  access_count,
        input  phase
    );
endinterface

// File: rtl/access_pattern_gen.sv
// Address-trace generator feeding the sector cache. Emits one address per
// cycle in a sequential, LFSR-random or line-reuse pattern (or all three in
// order), with stall back-pressure and a one-cycle done pulse.
// Optional feature macro: ACCESS_GEN_RAND_EN -- when defined the LFSR and the
// random phase are built; when undefined the random phase has zero accesses.
module access_pattern_gen #(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          SECTOR_SIZE    = 8,
    parameter int          LINE_SIZE      = 32,
    parameter logic [31:0] NUM_ACCESSES   = 32'd1000,
    parameter int          REUSE_PERIOD   = 100,
    parameter int          RAND_MASK_BITS = 16,
    parameter logic [31:0] LFSR_SEED      = 32'hACE1_0001
) (
    input  logic                  clk,
    input  logic                  rst,
    access_pattern_gen_if.master  bus
);

    localparam int SECTORS_PER_LINE = LINE_SIZE / SECTOR_SIZE;
    localparam int SECTOR_SHIFT     = $clog2(SECTOR_SIZE);

    localparam logic [31:0]           LAST_K           = NUM_ACCESSES - 32'd1;
    localparam logic [31:0]           REUSE_LAST       = 32'(REUSE_PERIOD - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_OFFSET_MASK = ADDR_WIDTH'(SECTORS_PER_LINE - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_STEP        = ADDR_WIDTH'(LINE_SIZE);

    localparam logic [1:0] PH_SEQ   = 2'd0;
    localparam logic [1:0] PH_RAND  = 2'd1;
    localparam logic [1:0] PH_REUSE = 2'd2;
    localparam logic [1:0] MODE_ALL = 2'd3;

`ifdef ACCESS_GEN_RAND_EN
    localparam bit          RAND_PRESENT = 1'b1;
    localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
`else
    localparam bit          RAND_PRESENT = 1'b0;
`endif

    // Reject configurations the address arithmetic cannot honour.
    if (LFSR_SEED == 32'd0 || RAND_MASK_BITS < 1 || RAND_MASK_BITS > ADDR_WIDTH ||
        REUSE_PERIOD < 1 || SECTORS_PER_LINE < 1 ||
        (1 << SECTOR_SHIFT) != SECTOR_SIZE) begin : g_bad_cfg
        $error("access_pattern_gen: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [1:0]            mode_reg, mode_next;
    logic [1:0]            phase_reg, phase_next;
    logic [31:0]           k_reg, k_next;
    logic [31:0]           count_reg, count_next;
    logic [31:0]           rc_reg, rc_next;
    logic [ADDR_WIDTH-1:0] base_reg, base_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic                  valid_reg, valid_next;
    logic                  busy_reg, busy_next;
    logic                  done_reg, done_next;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] seq_addr;
    logic [ADDR_WIDTH-1:0] reuse_addr;

`ifdef ACCESS_GEN_RAND_EN
    logic [31:0]           lfsr_reg, lfsr_next;
    logic [ADDR_WIDTH-1:0] rand_mask;
    logic [ADDR_WIDTH-1:0] rand_addr;

    // Bit-wise mask keeping only the low RAND_MASK_BITS address bits.
    for (genvar gi = 0; gi < ADDR_WIDTH; gi++) begin : g_rand_mask
        assign rand_mask[gi] = (gi < RAND_MASK_BITS);
    end

    assign rand_addr = ADDR_WIDTH'(lfsr_next) & rand_mask;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction
`endif

    // Mode 3 starts with the sequential phase; the others run just their own.
    function automatic logic [1:0] first_phase(input logic [1:0] m);
        return (m == MODE_ALL) ? PH_SEQ : m;
    endfunction

    function automatic logic phase_empty(input logic [1:0] p);
        return (NUM_ACCESSES == 32'd0) || (p == PH_RAND && !RAND_PRESENT);
    endfunction

    // In mode 3 the random phase is skipped when it is not built.
    function automatic logic [1:0] after_phase(input logic [1:0] p);
        return (p == PH_SEQ && RAND_PRESENT) ? PH_RAND : PH_REUSE;
    endfunction

    assign accept = valid_reg & ~bus.stall;

    // FSM next-state and run bookkeeping (k, count, reuse base, LFSR).
    always_comb begin
        state_next = state_reg;
        mode_next  = mode_reg;
        phase_next = phase_reg;
        k_next     = k_reg;
        count_next = count_reg;
        rc_next    = rc_reg;
        base_next  = base_reg;
        valid_next = 1'b0;
        busy_next  = 1'b0;
        done_next  = 1'b0;
`ifdef ACCESS_GEN_RAND_EN
        lfsr_next  = lfsr_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    mode_next  = bus.mode;
                    phase_next = first_phase(bus.mode);
                    k_next     = 32'd0;
                    count_next = 32'd0;
                    rc_next    = 32'd0;
                    base_next  = '0;
`ifdef ACCESS_GEN_RAND_EN
                    lfsr_next  = LFSR_SEED;
`endif
                    busy_next  = 1'b1;
                    if (phase_empty(first_phase(bus.mode))) begin
                        state_next = FINISH;
                        done_next  = 1'b1;
                    end else begin
                        state_next = RUN;
                        valid_next = 1'b1;
                    end
                end
            end
            RUN: begin
                busy_next  = 1'b1;
                valid_next = 1'b1;
                if (accept) begin
                    count_next = count_reg + 32'd1;
                    k_next     = k_reg + 32'd1;
                    if (phase_reg == PH_REUSE) begin
                        if (rc_reg == REUSE_LAST) begin
                            rc_next   = 32'd0;
                            base_next = base_reg + LINE_STEP;
                        end else begin
                            rc_next = rc_reg + 32'd1;
                        end
                    end
`ifdef ACCESS_GEN_RAND_EN
                    if (phase_reg == PH_RAND) begin
                        lfsr_next = lfsr_step(lfsr_reg);
                    end
`endif
                    if (k_reg == LAST_K) begin
                        if (mode_reg == MODE_ALL && phase_reg != PH_REUSE) begin
                            phase_next = after_phase(phase_reg);
                            k_next     = 32'd0;
                            rc_next    = 32'd0;
                        end else begin
                            state_next = FINISH;
                            valid_next = 1'b0;
                            done_next  = 1'b1;
                        end
                    end
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Next address: computed from the post-update k/base/LFSR whenever a new
    // access is presented; otherwise the address register holds.
    always_comb begin
        addr_next  = addr_reg;
        seq_addr   = ADDR_WIDTH'(k_next) << SECTOR_SHIFT;
        reuse_addr = base_next + ((ADDR_WIDTH'(k_next) & LINE_OFFSET_MASK) << SECTOR_SHIFT);
        if (state_next == RUN && (state_reg != RUN || accept)) begin
            case (phase_next)
                PH_REUSE: addr_next = reuse_addr;
`ifdef ACCESS_GEN_RAND_EN
                PH_RAND:  addr_next = rand_addr;
`endif
                default:  addr_next = seq_addr;
            endcase
        end
    end

    // State and output registers; reset forces every output to idle values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            mode_reg  <= 2'd0;
            phase_reg <= 2'd0;
            k_reg     <= 32'd0;
            count_reg <= 32'd0;
            rc_reg    <= 32'd0;
            base_reg  <= '0;
            addr_reg  <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            mode_reg  <= mode_next;
            phase_reg <= phase_next;
            k_reg     <= k_next;
            count_reg <= count_next;
            rc_reg    <= rc_next;
            base_reg  <= base_next;
            addr_reg  <= addr_next;
            valid_reg <= valid_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

`ifdef ACCESS_GEN_RAND_EN
    // LFSR register, reloaded with the seed on reset and on every start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end
`endif

    assign bus.addr         = addr_reg;
    assign bus.addr_valid   = valid_reg;
    assign bus.busy         = busy_reg;
    assign bus.done         = done_reg;
    assign bus.access_count = count_reg;
    assign bus.phase        = phase_reg;

endmodule
